// File: rtl/bus_register_bank.sv
// DEPTH x WIDTH register bank: one write port (load/inc/dec/clear), two zero-forced read ports.
// Latency: writes land on the next CLK edge; reads are combinational from stored state.
// No backpressure; optional BUS_REGISTER_BANK_BYPASS_EN forwards same-cycle write data to reads.
module bus_register_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              CLR_n,
    input  logic              WE_n,
    input  logic [ADDR_W-1:0] WA,
    input  logic [1:0]        OP,
    input  logic [WIDTH-1:0]  D,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    input  logic              OEA_n,
    input  logic              OEB_n,
    output logic [WIDTH-1:0]  QA,
    output logic [WIDTH-1:0]  QB,
    output logic              DRVA,
    output logic              DRVB,
    output logic              CF,
    output logic              ZF
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             cf_q, cf_d;
    logic             zf_q, zf_d;

    logic             wa_ok;
    logic             wr_act;
    logic [WIDTH-1:0] wr_cur;
    logic [WIDTH-1:0] wr_dat;
    logic             wr_cf;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;

    // Compute the value/flags a write would produce, independent of whether it happens.
    always_comb begin
        wa_ok  = ({1'b0, WA} < DEPTH_L);
        wr_act = CLR_n && !WE_n && wa_ok;

        wr_cur = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (WA == ADDR_W'(i)) begin
                wr_cur = mem_q[i];
            end
        end

        wr_dat = wr_cur;
        wr_cf  = cf_q;
        case (OP)
            OP_LOAD: begin
                wr_dat = D;
                wr_cf  = cf_q;
            end
            OP_INC: begin
                {wr_cf, wr_dat} = {1'b0, wr_cur} + (WIDTH + 1)'(1);
            end
            OP_DEC: begin
                wr_dat = wr_cur - WIDTH'(1);
                wr_cf  = (wr_cur == '0);
            end
            OP_CLR: begin
                wr_dat = '0;
                wr_cf  = cf_q;
            end
            default: begin
                wr_dat = wr_cur;
                wr_cf  = cf_q;
            end
        endcase
    end

    always_comb begin
        mem_d = mem_q;
        cf_d  = cf_q;
        zf_d  = zf_q;
        if (wr_act) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (WA == ADDR_W'(i)) begin
                    mem_d[i] = wr_dat;
                end
            end
            cf_d = wr_cf;
            zf_d = (wr_dat == '0);
        end
    end

    always_ff @(posedge CLK) begin
        if (!CLR_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            cf_q <= 1'b0;
            zf_q <= 1'b0;
        end else begin
            mem_q <= mem_d;
            cf_q  <= cf_d;
            zf_q  <= zf_d;
        end
    end

    // Read side: out-of-range addresses never drive, and undriven ports are forced to zero.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (RA == ADDR_W'(i)) begin
                rd_a = mem_q[i];
            end
            if (RB == ADDR_W'(i)) begin
                rd_b = mem_q[i];
            end
        end
`ifdef BUS_REGISTER_BANK_BYPASS_EN
        if (wr_act && (RA == WA)) begin
            rd_a = wr_dat;
        end
        if (wr_act && (RB == WA)) begin
            rd_b = wr_dat;
        end
`endif
        DRVA = !OEA_n && ({1'b0, RA} < DEPTH_L);
        DRVB = !OEB_n && ({1'b0, RB} < DEPTH_L);
        QA   = DRVA ? rd_a : '0;
        QB   = DRVB ? rd_b : '0;
    end

    assign CF = cf_q;
    assign ZF = zf_q;

endmodule

// File: tb/tb_bus_register_bank.sv
// Directed bench for bus_register_bank: a DEPTH=4 and a DEPTH=3 instance share all inputs.
module tb_bus_register_bank;

    logic       CLK;
    logic       CLR_n;
    logic       WE_n;
    logic [1:0] WA;
    logic [1:0] OP;
    logic [7:0] D;
    logic [1:0] RA;
    logic [1:0] RB;
    logic       OEA_n;
    logic       OEB_n;

    logic [7:0] qa, qb, qa3, qb3;
    logic       drva, drvb, cf, zf;
    logic       drva3, drvb3, cf3, zf3;

    int n_chk = 0;
    int n_err = 0;

    bus_register_bank #(.WIDTH(8), .DEPTH(4)) u_dut (
        .CLK(CLK), .CLR_n(CLR_n), .WE_n(WE_n), .WA(WA), .OP(OP), .D(D),
        .RA(RA), .RB(RB), .OEA_n(OEA_n), .OEB_n(OEB_n),
        .QA(qa), .QB(qb), .DRVA(drva), .DRVB(drvb), .CF(cf), .ZF(zf)
    );

    bus_register_bank #(.WIDTH(8), .DEPTH(3)) u_dut3 (
        .CLK(CLK), .CLR_n(CLR_n), .WE_n(WE_n), .WA(WA), .OP(OP), .D(D),
        .RA(RA), .RB(RB), .OEA_n(OEA_n), .OEB_n(OEB_n),
        .QA(qa3), .QB(qb3), .DRVA(drva3), .DRVB(drvb3), .CF(cf3), .ZF(zf3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [1:0] wa, input logic [1:0] op, input logic [7:0] d);
        WE_n = 1'b0;
        WA   = wa;
        OP   = op;
        D    = d;
        tick();
        WE_n = 1'b1;
    endtask

    initial begin
        logic [7:0] same_exp;
        CLR_n = 1'b0; WE_n = 1'b1; WA = '0; OP = '0; D = '0;
        RA = '0; RB = '0; OEA_n = 1'b1; OEB_n = 1'b1;
        tick();
        tick();
        check("rst_qa_oe_off", qa, 8'h00);
        check("rst_drva_oe_off", drva, 1'b0);
        check("rst_cf", cf, 1'b0);
        check("rst_zf", zf, 1'b0);
        CLR_n = 1'b1;

        // Dirty every register and CF, then reset with a write pending on the same edge.
        for (int i = 0; i < 4; i++) wr(2'(i), 2'b00, 8'($urandom_range(1, 255)));
        wr(2'd0, 2'b11, 8'h00);
        wr(2'd0, 2'b10, 8'h00);
        check("pre_rst_cf", cf, 1'b1);
        CLR_n = 1'b0; WE_n = 1'b0; WA = 2'd1; OP = 2'b00; D = 8'hAB;
        tick();
        CLR_n = 1'b1; WE_n = 1'b1;
        OEA_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            RA = 2'(i);
            #1;
            check("rst_reg_zero", qa, 8'h00);
            check("rst_reg_drva", drva, 1'b1);
        end
        check("rst2_cf", cf, 1'b0);
        check("rst2_zf", zf, 1'b0);

        // Load and dual read.
        wr(2'd1, 2'b00, 8'h5A);
        wr(2'd2, 2'b00, 8'hC3);
        RA = 2'd1; RB = 2'd2; OEA_n = 1'b0; OEB_n = 1'b0;
        #1;
        check("load_qa", qa, 8'h5A);
        check("load_qb", qb, 8'hC3);
        check("load_drva", drva, 1'b1);
        check("load_drvb", drvb, 1'b1);
        OEA_n = 1'b1;
        #1;
        check("oea_off_qa", qa, 8'h00);
        check("oea_off_drva", drva, 1'b0);
        check("oea_off_qb", qb, 8'hC3);
        OEA_n = 1'b0;

        // Increment wrap on reg0.
        RA = 2'd0;
        wr(2'd0, 2'b00, 8'hFE);
        wr(2'd0, 2'b01, 8'h00);
        check("inc1_q", qa, 8'hFF);
        check("inc1_cf", cf, 1'b0);
        check("inc1_zf", zf, 1'b0);
        wr(2'd0, 2'b01, 8'h00);
        check("inc2_q", qa, 8'h00);
        check("inc2_cf", cf, 1'b1);
        check("inc2_zf", zf, 1'b1);
        wr(2'd0, 2'b01, 8'h00);
        check("inc3_cf", cf, 1'b0);

        // Clear then decrement borrow, then load zero keeps CF.
        RA = 2'd3;
        wr(2'd3, 2'b11, 8'h55);
        check("clr_q", qa, 8'h00);
        check("clr_zf", zf, 1'b1);
        check("clr_cf_held", cf, 1'b0);
        wr(2'd3, 2'b10, 8'h00);
        check("dec_q", qa, 8'hFF);
        check("dec_cf", cf, 1'b1);
        check("dec_zf", zf, 1'b0);
        wr(2'd3, 2'b00, 8'h00);
        check("ld0_q", qa, 8'h00);
        check("ld0_zf", zf, 1'b1);
        check("ld0_cf_held", cf, 1'b1);

        // Invalid address on the DEPTH=3 instance.
        CLR_n = 1'b0;
        tick();
        CLR_n = 1'b1;
        wr(2'd0, 2'b00, 8'h11);
        wr(2'd1, 2'b00, 8'h22);
        wr(2'd2, 2'b00, 8'h00);
        wr(2'd2, 2'b10, 8'h00);
        check("d3_setup_cf", cf3, 1'b1);
        check("d3_setup_zf", zf3, 1'b0);
        wr(2'd3, 2'b00, 8'h77);
        RA = 2'd3;
        #1;
        check("d3_inv_qa", qa3, 8'h00);
        check("d3_inv_drva", drva3, 1'b0);
        check("d4_wa3_qa", qa, 8'h77);
        check("d4_wa3_drva", drva, 1'b1);
        wr(2'd3, 2'b11, 8'h00);
        check("d3_inv_cf", cf3, 1'b1);
        check("d3_inv_zf", zf3, 1'b0);
        RA = 2'd0; RB = 2'd1;
        #1;
        check("d3_reg0", qa3, 8'h11);
        check("d3_reg1", qb3, 8'h22);
        RA = 2'd2;
        #1;
        check("d3_reg2", qa3, 8'hFF);

        // Same-cycle read of the register being incremented.
`ifdef BUS_REGISTER_BANK_BYPASS_EN
        same_exp = 8'h11;
`else
        same_exp = 8'h10;
`endif
        wr(2'd1, 2'b00, 8'h10);
        RA = 2'd1; RB = 2'd1;
        WE_n = 1'b0; WA = 2'd1; OP = 2'b01;
        #1;
        check("same_qa", qa, 32'(same_exp));
        check("same_qb", qb, 32'(same_exp));
        tick();
        WE_n = 1'b1;
        check("after_qa", qa, 8'h11);
        check("after_qb", qb, 8'h11);

        // Same again with reset on the edge: no forwarding while reset is asserted.
        wr(2'd1, 2'b00, 8'h10);
        WE_n = 1'b0; WA = 2'd1; OP = 2'b01; CLR_n = 1'b0;
        #1;
        check("rst_same_qa", qa, 8'h10);
        tick();
        CLR_n = 1'b1; WE_n = 1'b1;
        check("rst_same_after_qa", qa, 8'h00);
        check("rst_same_cf", cf, 1'b0);
        check("rst_same_zf", zf, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
